// File: rtl/add_seq_pkg.sv
// Shared definitions for the chunked sequential adder/subtractor.
//   state_t    : FSM encoding (IDLE, RUN, DONE), 2 bits
//   DEF_WIDTH  : default operand width
//   DEF_CHUNK  : default bits summed per cycle
//   idx_w(n)   : width of a slice index for n slices (minimum 1)
package add_seq_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit full adder, one slice of the sequential adder.
// Ports:
//   a, b : slice operands
//   ci   : carry in
//   s    : slice sum
//   co   : carry out
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/add_seq_chunked.sv
// Multi-cycle adder/subtractor: sums a WIDTH-bit operand pair CHUNK bits
// per clock, keeping the carry in a register between slices. Short carry
// path, latency of WIDTH/CHUNK RUN cycles plus the DONE entry.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand handshake, accepted only in IDLE
//   a, b, ci, sub       : operands; sub=1 computes a-b (ci ignored)
//   out_valid/out_ready : result handshake, result held while stalled
//   result              : {flag, sum}; flag = carry (add) or borrow (sub)
// Build option: define ADD_SEQ_SAT_EN for unsigned saturation of the sum
// (all ones on add overflow, zero on subtract underflow).
module add_seq_chunked
  import add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("add_seq_chunked: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t state, state_nxt;

  logic [N-1:0][CHUNK-1:0] a_r, b_r, sum_r;
  logic                    carry, sub_r, flag_r;
  logic [IW-1:0]           idx;

  logic [CHUNK-1:0]        s;
  logic                    co;
  logic                    last;
  logic                    fin_flag;
  logic                    sat;
  logic [N-1:0][CHUNK-1:0] sat_val;

  // Single adder slice, steered across the operand by idx.
  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_r[idx]),
    .b  (b_r[idx]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last = (idx == LAST);
  // Subtract runs as a + ~b + 1, so a missing carry-out means a borrow.
  assign fin_flag = sub_r ? ~co : co;

`ifdef ADD_SEQ_SAT_EN
  assign sat     = fin_flag;
  assign sat_val = sub_r ? '0 : '1;
`else
  assign sat     = 1'b0;
  assign sat_val = '0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      flag_r <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub | ci;
            sub_r <= sub;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          sum_r[idx] <= s;
          carry      <= co;
          if (last) begin
            flag_r <= fin_flag;
            // Saturation overrides the whole sum on the final slice edge.
            if (sat) sum_r <= sat_val;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = {flag_r, sum_r};

endmodule
